// File: rtl/rotary_pkg.sv
// ---------------------------------------------------------------------------
// rotary_pkg
// Shared types for the rotary cursor slice.
//   state_t : acceleration FSM states (IDLE, SLOW, FAST)
//   dir_t   : direction of the most recent rotary event (DIR_CW, DIR_CCW)
// No ports (package).
// ---------------------------------------------------------------------------
package rotary_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } state_t;

  // DIR_CCW is encoded as 1 so the raw ccw pulse can serve as the direction
  // bit whenever exactly one of cw/ccw is high.
  typedef enum logic {
    DIR_CW  = 1'b0,
    DIR_CCW = 1'b1
  } dir_t;

endpackage

// File: rtl/rotary_accel.sv
// ---------------------------------------------------------------------------
// rotary_accel
// Interval timer plus IDLE/SLOW/FAST acceleration FSM. Produces the step size
// that the cursor applies to the event presented in the same cycle.
// Only instantiated when ROTARY_ACCEL_EN is defined.
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   i_evt   in   1 = exactly one of cw/ccw is high this cycle
//   i_dir   in   direction of the event (0 = cw, 1 = ccw), valid with i_evt
//   o_step  out  step size for the current event (combinational)
// ---------------------------------------------------------------------------
module rotary_accel
  import rotary_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FAST_WINDOW = 500000,
  parameter int FAST_STEP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_evt,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_step
);

  localparam int              TW        = $clog2(FAST_WINDOW + 1);
  localparam logic [TW-1:0]    WINDOW    = TW'(FAST_WINDOW);
  localparam logic [WIDTH-1:0] STEP_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_FAST = WIDTH'(FAST_STEP);

  state_t        r_state, w_state_next;
  logic [TW-1:0] r_timer, w_timer_next;
  dir_t          r_last_dir, w_last_dir_next;
  dir_t          w_dir;
  logic          w_same_dir;
  logic          w_in_window;

  assign w_dir       = dir_t'(i_dir);
  assign w_same_dir  = (w_dir == r_last_dir);
  assign w_in_window = (r_timer < WINDOW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_last_dir <= DIR_CW;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_last_dir <= w_last_dir_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_last_dir_next = r_last_dir;
    o_step          = STEP_ONE;

    if (i_evt) begin
      w_timer_next    = '0;
      w_last_dir_next = w_dir;
      case (r_state)
        IDLE: w_state_next = SLOW;
        SLOW: w_state_next = (w_same_dir && w_in_window) ? FAST : SLOW;
        FAST: begin
          if (w_same_dir && w_in_window) begin
            w_state_next = FAST;
            o_step       = STEP_FAST;
          end else begin
            w_state_next = SLOW;
          end
        end
        default: w_state_next = SLOW;
      endcase
    end else begin
      // Timer saturates at the window; the cycle it gets there the FSM
      // falls back to IDLE so a slow spin never inherits acceleration.
      if (w_in_window) begin
        w_timer_next = r_timer + TW'(1);
      end
      if (w_timer_next == WINDOW) begin
        w_state_next = IDLE;
      end
    end
  end

endmodule

// File: rtl/rotary_cursor.sv
// ---------------------------------------------------------------------------
// rotary_cursor
// Cursor position register driven by rotary encoder event pulses, with a
// valid/ready change notification towards the display pipeline.
// Optional acceleration: define ROTARY_ACCEL_EN to compile in rotary_accel
// (IDLE/SLOW/FAST FSM + interval timer). Without it the step is always 1 and
// FAST_WINDOW / FAST_STEP have no effect.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   rotary_cw   in   single-cycle clockwise event pulse
//   rotary_ccw  in   single-cycle counter-clockwise event pulse
//   pos         out  registered cursor position (WIDTH bits)
//   pos_valid   out  position changed since last accepted transfer
//   pos_ready   in   consumer accepts pos when pos_valid && pos_ready
// ---------------------------------------------------------------------------
module rotary_cursor
  import rotary_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int INIT        = 0,
  parameter int WRAP        = 0,
  parameter int FAST_WINDOW = 500000,
  parameter int FAST_STEP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rotary_cw,
  input  logic             rotary_ccw,
  output logic [WIDTH-1:0] pos,
  output logic             pos_valid,
  input  logic             pos_ready
);

  logic [WIDTH-1:0] r_pos;
  logic             r_pos_valid;
  logic             w_evt;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_pos_cand;
  logic             w_change;

  // Both pulses together cancel out and count as no event.
  assign w_evt = rotary_cw ^ rotary_ccw;

`ifdef ROTARY_ACCEL_EN
  rotary_accel #(
    .WIDTH       (WIDTH),
    .FAST_WINDOW (FAST_WINDOW),
    .FAST_STEP   (FAST_STEP)
  ) u_accel (
    .clk    (clk),
    .reset  (reset),
    .i_evt  (w_evt),
    .i_dir  (rotary_ccw),
    .o_step (w_step)
  );
`else
  assign w_step = WIDTH'(1);

  // Acceleration parameters stay on the interface so both builds share one
  // instantiation template; they are intentionally not consumed here.
  logic w_unused_params;
  assign w_unused_params = ^{FAST_WINDOW[0], FAST_STEP[0]};
`endif

  // One extra bit on add/subtract exposes carry/borrow, which is exactly
  // the "would leave the range" condition needed for saturation.
  always_comb begin
    w_sum      = {1'b0, r_pos} + {1'b0, w_step};
    w_diff     = {1'b0, r_pos} - {1'b0, w_step};
    w_pos_cand = r_pos;
    if (rotary_cw) begin
      if (WRAP != 0 || !w_sum[WIDTH]) w_pos_cand = w_sum[WIDTH-1:0];
      else                             w_pos_cand = '1;
    end else begin
      if (WRAP != 0 || !w_diff[WIDTH]) w_pos_cand = w_diff[WIDTH-1:0];
      else                              w_pos_cand = '0;
    end
    // A saturated event that lands on the current value is not a change.
    w_change = w_evt && (w_pos_cand != r_pos);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos       <= WIDTH'(INIT);
      r_pos_valid <= 1'b0;
    end else if (w_change) begin
      // A change wins over a same-cycle acceptance: the new value is unseen.
      r_pos       <= w_pos_cand;
      r_pos_valid <= 1'b1;
    end else if (r_pos_valid && pos_ready) begin
      r_pos_valid <= 1'b0;
    end
  end

  assign pos       = r_pos;
  assign pos_valid = r_pos_valid;

endmodule

// File: doc/rotary_cursor.md
ROTARY_CURSOR -- requirements
Module: rotary_cursor

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the position register.
REQ-002 Parameter INIT, default 0: position value loaded at reset.
REQ-003 Parameter WRAP, default 0: 0 saturates at the bounds, 1 wraps modulo 2^WIDTH.
REQ-004 Parameter FAST_WINDOW, default 500000: inter-event cycle window for acceleration (10 ms at 50 MHz).
REQ-005 Parameter FAST_STEP, default 4: step size applied in the FAST state.
REQ-006 Port clk, input, 1: the single clock; all logic is rising-edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port rotary_cw, input, 1: single-cycle clockwise event pulse from the upstream rotary decoder.
REQ-009 Port rotary_ccw, input, 1: single-cycle counter-clockwise event pulse.
REQ-010 Port pos, output, WIDTH: registered current cursor position (feeds the seven-seg and draw stages).
REQ-011 Port pos_valid, output, 1: position has changed since the last accepted transfer.
REQ-012 Port pos_ready, input, 1: consumer accepts pos when pos_valid && pos_ready.

Function
REQ-013 Event = exactly one of rotary_cw/rotary_ccw high in a cycle; both high or both low = no event, no state change.
REQ-014 cw adds step, ccw subtracts step; an event in cycle N is visible on pos in cycle N+1.
REQ-015 WRAP=0: result clamps to [0, 2^WIDTH-1]; e.g. pos=254, step 4, cw -> 255.
REQ-016 WRAP=1: result is computed modulo 2^WIDTH; e.g. pos=254, step 4, cw -> 2.
REQ-017 Event producing no change (saturated at a bound) leaves pos and pos_valid untouched.
REQ-018 Any change to pos sets pos_valid in the same cycle pos updates (N+1).
REQ-019 pos_valid && pos_ready clears pos_valid next cycle, unless pos changes in that same cycle (then valid stays 1).
REQ-020 pos always reflects the latest value; updates while pos_valid=1 overwrite pos (no queueing), and valid remains 1.
REQ-021 Without acceleration (see Configuration) step is always 1.

Reset
REQ-022 Asynchronous assertion of reset: pos=INIT, pos_valid=0, state=IDLE, interval timer=0, last direction=cw.
REQ-023 Events coincident with reset or during reset are discarded; the first event after deassertion is handled as from IDLE.

Configuration
REQ-024 Macro ROTARY_ACCEL_EN defined: acceleration FSM with states IDLE, SLOW, FAST and an interval timer are compiled in.
REQ-025 Timer resets to 0 on every event, else increments and saturates at FAST_WINDOW; reaching FAST_WINDOW forces IDLE.
REQ-026 IDLE --event--> SLOW, step 1; SLOW --same-direction event, timer<FAST_WINDOW--> FAST, step 1.
REQ-027 FAST --same-direction event, timer<FAST_WINDOW--> FAST, step FAST_STEP.
REQ-028 SLOW/FAST --opposite-direction event--> SLOW, step 1.
REQ-029 Macro not defined: no FSM, no timer; step fixed at 1; FAST_WINDOW and FAST_STEP are unused.

Structure
REQ-030 Shared package rotary_pkg holds the state enum (IDLE, SLOW, FAST) and a direction typedef (DIR_CW, DIR_CCW).
REQ-031 Sub-module rotary_accel (timer + FSM, outputs step) is instantiated only under ROTARY_ACCEL_EN; position/handshake logic is in rotary_cursor.

Verification
REQ-032 Reset with INIT=10, then one cw pulse -> pos=11 and pos_valid=1 one cycle later; pos_ready=1 -> valid=0 next cycle.
REQ-033 WRAP=0, pos=0, ccw pulse -> pos stays 0, pos_valid stays 0; WRAP=1, same stimulus -> pos=255, pos_valid=1.
REQ-034 rotary_cw and rotary_ccw high together for 1 cycle -> pos unchanged, FSM state and timer unchanged.
REQ-035 ROTARY_ACCEL_EN, FAST_WINDOW=100: four cw pulses 20 cycles apart from pos=0 -> pos 1,2,6,10; idle 100 cycles -> IDLE; next cw -> +1.
REQ-036 In FAST, one ccw pulse -> step 1 and state SLOW; pos_ready=0 across 3 changes -> pos tracks latest value, valid held at 1.
REQ-037 Assert reset asynchronously mid-burst -> pos=INIT and pos_valid=0 immediately without a clock edge; state IDLE.
